// File: rtl/iob_bunpack_pkg.sv
// ============================================================================
// Module  : iob_bunpack_pkg
// Brief   : Shared types and helpers for the iob_bunpack bitstream unpacker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iob_bunpack_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    ALIGN = 1'b1
  } state_t;

  // Bits remaining to the next byte boundary; only called with bc != 0.
  function automatic logic [2:0] pad_bits(input logic [2:0] bc);
    return 3'd0 - bc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iob_bunpack_extract.sv
// ============================================================================
// Module  : iob_bunpack_extract
// Brief   : Combinational field extractor: rotate buffer to rptr, take the
//           leading rwidth bits right-justified, optionally sign-extended.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_bunpack_extract #(
  parameter int DATA_W = 21
) (
  input  logic [2*DATA_W-1:0]        bits_i,
  input  logic [$clog2(2*DATA_W)-1:0] rptr_i,
  input  logic [$clog2(DATA_W):0]    rwidth_i,
  input  logic                       sign_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int BUF_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(BUF_W);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] c_buf = LVL_W'(BUF_W);

  logic [BUF_W-1:0] w_rot;
  logic [LVL_W-1:0] w_shamt;

  // Oldest unread bit lands at the MSB after the rotate.
  assign w_rot   = (bits_i << rptr_i) | (bits_i >> (c_buf - LVL_W'(rptr_i)));
  assign w_shamt = c_buf - LVL_W'(rwidth_i);

  always_comb begin
    rdata_o = DATA_W'(w_rot >> w_shamt);
    if (sign_i && (rwidth_i != '0)) begin
      rdata_o = DATA_W'($signed(w_rot) >>> w_shamt);
    end
  end

endmodule

`default_nettype wire

// File: rtl/iob_bunpack.sv
// ============================================================================
// Module  : iob_bunpack
// Brief   : MSB-first bitstream unpacker: DATA_W-bit words in, 0..DATA_W bit
//           fields out, with byte-alignment skip. Optional sign extension
//           via macro IOB_BUNPACK_SIGN_EXT_EN (adds sign_i).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_bunpack
  import iob_bunpack_pkg::*;
#(
  parameter int DATA_W = 21
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_n_i,
  input  logic                          rst_i,
  input  logic [DATA_W-1:0]             wdata_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  input  logic [$clog2(DATA_W):0]       rwidth_i,
`ifdef IOB_BUNPACK_SIGN_EXT_EN
  input  logic                          sign_i,
`endif
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  input  logic                          align_i,
  output logic                          busy_o,
  output logic [$clog2(2*DATA_W):0]     level_o
);

  localparam int BUF_W = 2 * DATA_W;
  localparam int PTR_W = $clog2(BUF_W);
  localparam int LVL_W = PTR_W + 1;
  localparam int WID_W = $clog2(DATA_W) + 1;

  localparam logic [LVL_W-1:0] c_lvl_dw  = LVL_W'(DATA_W);
  localparam logic [LVL_W-1:0] c_lvl_buf = LVL_W'(BUF_W);
  localparam logic [WID_W-1:0] c_wid_dw  = WID_W'(DATA_W);

  logic [BUF_W-1:0] r_buf,    w_buf_nxt;
  logic [PTR_W-1:0] r_rptr,   w_rptr_nxt;
  logic [PTR_W-1:0] r_wptr,   w_wptr_nxt;
  logic [LVL_W-1:0] r_level,  w_level_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic [2:0]       r_pad,    w_pad_nxt;
  state_t           r_state,  w_state_nxt;

  logic [WID_W-1:0] w_rw;
  logic [LVL_W-1:0] w_adv;
  logic [LVL_W-1:0] w_rsum;
  logic             w_wr;
  logic             w_rd;
  logic             w_skip;
  logic             w_sign;

`ifdef IOB_BUNPACK_SIGN_EXT_EN
  assign w_sign = sign_i;
`else
  assign w_sign = 1'b0;
`endif

  assign w_rw     = (rwidth_i > c_wid_dw) ? c_wid_dw : rwidth_i;
  assign wready_o = (r_level <= c_lvl_dw);
  assign rvalid_o = (r_state == RUN) && (r_level >= LVL_W'(w_rw));
  assign busy_o   = (r_state == ALIGN);
  assign level_o  = r_level;

  assign w_wr   = wvalid_i && wready_o;
  assign w_rd   = rvalid_o && rready_i;
  assign w_skip = (r_state == ALIGN) && (r_level >= LVL_W'(r_pad));

  // Reads and skips are mutually exclusive since reads require RUN.
  assign w_adv  = w_rd ? LVL_W'(w_rw) : (w_skip ? LVL_W'(r_pad) : '0);
  assign w_rsum = LVL_W'(r_rptr) + w_adv;

  iob_bunpack_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .bits_i   (r_buf),
    .rptr_i   (r_rptr),
    .rwidth_i (w_rw),
    .sign_i   (w_sign),
    .rdata_o  (rdata_o)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pad_nxt    = r_pad;
    w_bitcnt_nxt = r_bitcnt;
    w_buf_nxt    = r_buf;
    w_wptr_nxt   = r_wptr;
    w_rptr_nxt   = (w_rsum >= c_lvl_buf) ? PTR_W'(w_rsum - c_lvl_buf) : PTR_W'(w_rsum);
    w_level_nxt  = r_level + (w_wr ? c_lvl_dw : '0) - w_adv;

    // wptr only ever sits on a half boundary, so a write fills one half.
    if (w_wr) begin
      if (r_wptr == '0) begin
        w_buf_nxt[BUF_W-1 -: DATA_W] = wdata_i;
        w_wptr_nxt                   = PTR_W'(DATA_W);
      end else begin
        w_buf_nxt[DATA_W-1:0] = wdata_i;
        w_wptr_nxt            = '0;
      end
    end

    case (r_state)
      RUN: begin
        if (w_rd) begin
          w_bitcnt_nxt = r_bitcnt + w_rw[2:0];
        end
        if (align_i && (w_bitcnt_nxt != 3'd0)) begin
          w_pad_nxt   = pad_bits(w_bitcnt_nxt);
          w_state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        if (w_skip) begin
          w_bitcnt_nxt = 3'd0;
          w_state_nxt  = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_buf    <= '0;
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_level  <= '0;
      r_bitcnt <= 3'd0;
      r_pad    <= 3'd0;
      r_state  <= RUN;
    end else if (cke_i) begin
      if (rst_i) begin
        r_buf    <= '0;
        r_rptr   <= '0;
        r_wptr   <= '0;
        r_level  <= '0;
        r_bitcnt <= 3'd0;
        r_pad    <= 3'd0;
        r_state  <= RUN;
      end else begin
        r_buf    <= w_buf_nxt;
        r_rptr   <= w_rptr_nxt;
        r_wptr   <= w_wptr_nxt;
        r_level  <= w_level_nxt;
        r_bitcnt <= w_bitcnt_nxt;
        r_pad    <= w_pad_nxt;
        r_state  <= w_state_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_bunpack.sv
// ============================================================================
// Module  : tb_iob_bunpack
// Brief   : Self-checking bench for iob_bunpack (DATA_W = 8) against a
//           bit-queue model, plus hand-computed directed expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_bunpack;

  localparam int DW = 8;

  logic       clk    = 1'b0;
  logic       cke    = 1'b1;
  logic       arst_n = 1'b0;
  logic       rst    = 1'b0;
  logic [7:0] wdata  = 8'h00;
  logic       wvalid = 1'b0;
  logic       wready;
  logic [3:0] rwidth = 4'd3;
  logic       sign   = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready = 1'b0;
  logic       align  = 1'b0;
  logic       busy;
  logic [4:0] level;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: unread bits oldest-first, alignment flag, pad, consumed total.
  bit mq[$];
  bit m_aln  = 1'b0;
  int m_pad  = 0;
  int m_cons = 0;

  iob_bunpack #(.DATA_W(DW)) dut (
    .clk_i    (clk),
    .cke_i    (cke),
    .arst_n_i (arst_n),
    .rst_i    (rst),
    .wdata_i  (wdata),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .rwidth_i (rwidth),
`ifdef IOB_BUNPACK_SIGN_EXT_EN
    .sign_i   (sign),
`endif
    .rdata_o  (rdata),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .align_i  (align),
    .busy_o   (busy),
    .level_o  (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_w();
    return (int'(rwidth) > DW) ? DW : int'(rwidth);
  endfunction

  function automatic bit eff_sign();
`ifdef IOB_BUNPACK_SIGN_EXT_EN
    return sign;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_data(input int rw);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < rw; i++) v = {v[6:0], mq[i]};
    if (eff_sign() && rw > 0 && mq[0]) begin
      for (int i = rw; i < 8; i++) v[i] = 1'b1;
    end
    return int'(v);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_aln  = 1'b0;
    m_pad  = 0;
    m_cons = 0;
  endtask

  // Model update at each active edge from pre-edge inputs.
  initial forever begin : model_proc
    int  rw;
    int  lvl;
    bit  wacc;
    @(posedge clk or negedge arst_n);
    if (!arst_n) begin
      model_clear();
    end else if (cke) begin
      if (rst) begin
        model_clear();
      end else begin
        rw   = sat_w();
        lvl  = mq.size();
        wacc = wvalid && (lvl <= DW);
        if (!m_aln) begin
          if (rready && lvl >= rw) begin
            for (int i = 0; i < rw; i++) void'(mq.pop_front());
            m_cons += rw;
          end
          if (align && (m_cons % 8) != 0) begin
            m_aln = 1'b1;
            m_pad = 8 - (m_cons % 8);
          end
        end else if (lvl >= m_pad) begin
          for (int i = 0; i < m_pad; i++) void'(mq.pop_front());
          m_cons += m_pad;
          m_aln   = 1'b0;
        end
        if (wacc) begin
          for (int i = 7; i >= 0; i--) mq.push_back(wdata[i]);
        end
      end
    end
  end

  // Compare every cycle on the inactive edge.
  initial forever begin : cmp_proc
    int rw;
    bit ev;
    @(negedge clk);
    rw = sat_w();
    ev = !m_aln && (mq.size() >= rw);
    chk("m_level",  int'(level),  mq.size());
    chk("m_wready", int'(wready), int'(mq.size() <= DW));
    chk("m_rvalid", int'(rvalid), int'(ev));
    chk("m_busy",   int'(busy),   int'(m_aln));
    if (ev) chk("m_rdata", int'(rdata), exp_data(rw));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] w);
    int k;
    wdata  = w;
    wvalid = 1'b1;
    k      = 0;
    @(negedge clk);
    while (!wready && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (k >= 20) chk("wr_timeout", 0, 1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic rd(input int w, input int exp, input int lvl, input string nm);
    rwidth = 4'(w);
    rready = 1'b1;
    @(negedge clk);
    chk({nm, "_level"},  int'(level),  lvl);
    chk({nm, "_rvalid"}, int'(rvalid), 1);
    chk({nm, "_rdata"},  int'(rdata),  exp);
    tick();
    rready = 1'b0;
    rwidth = 4'd0;
  endtask

  initial begin
    // Reset held with a nonzero width request
    @(negedge clk);
    chk("rst_level",  int'(level),  0);
    chk("rst_rvalid", int'(rvalid), 0);
    chk("rst_wready", int'(wready), 1);
    chk("rst_busy",   int'(busy),   0);
    tick();
    arst_n = 1'b1;
    rwidth = 4'd0;
    @(negedge clk);
    chk("w0_rvalid", int'(rvalid), 1);
    chk("w0_rdata",  int'(rdata),  0);
    tick();

    // Ordering
    wr(8'hA5);
    wr(8'h3C);
    rd(3, 'h05, 16, "ord0");
    rd(5, 'h05, 13, "ord1");
    rd(4, 'h03,  8, "ord2");
    rd(4, 'h0C,  4, "ord3");
    @(negedge clk);
    chk("ord_end_level", int'(level), 0);
    tick();

    // Full buffer with a pending word, then wrap
    wr(8'hFF);
    wr(8'h00);
    wdata  = 8'h81;
    wvalid = 1'b1;
    rwidth = 4'd8;
    rready = 1'b1;
    @(negedge clk);
    chk("full_level",  int'(level),  16);
    chk("full_wready", int'(wready), 0);
    chk("full_rdata",  int'(rdata),  'hFF);
    tick();
    rready = 1'b0;
    @(negedge clk);
    chk("full_wready1", int'(wready), 1);
    chk("full_level1",  int'(level),  8);
    tick();
    wvalid = 1'b0;
    rd(8, 'h00, 16, "wrap0");
    rd(8, 'h81,  8, "wrap1");

    // Simultaneous write and read
    wr(8'hC3);
    wdata  = 8'h5A;
    wvalid = 1'b1;
    rwidth = 4'd4;
    rready = 1'b1;
    @(negedge clk);
    chk("sim_rdata",  int'(rdata),  'h0C);
    chk("sim_wready", int'(wready), 1);
    tick();
    wvalid = 1'b0;
    rready = 1'b0;
    @(negedge clk);
    chk("sim_level", int'(level), 12);
    tick();
    rd(4, 'h03, 12, "sim1");
    rd(8, 'h5A,  8, "sim2");

    // Byte alignment
    wr(8'hA5);
    wr(8'h3C);
    rd(3, 'h05, 16, "aln0");
    align = 1'b1;
    @(negedge clk);
    chk("aln_busy0", int'(busy), 0);
    tick();
    align = 1'b0;
    @(negedge clk);
    chk("aln_busy1",   int'(busy),   1);
    chk("aln_level1",  int'(level),  13);
    chk("aln_rvalid1", int'(rvalid), 0);
    tick();
    @(negedge clk);
    chk("aln_busy2",  int'(busy),  0);
    chk("aln_level2", int'(level), 8);
    tick();
    rd(8, 'h3C, 8, "aln1");
    align = 1'b1;
    tick();
    align = 1'b0;
    @(negedge clk);
    chk("aln_noop_busy", int'(busy), 0);
    tick();

    // Align with a same-cycle read, and a write during ALIGN
    wr(8'hA5);
    rwidth = 4'd5;
    rready = 1'b1;
    align  = 1'b1;
    @(negedge clk);
    chk("alr_rdata", int'(rdata), 'h14);
    tick();
    rready = 1'b0;
    align  = 1'b0;
    rwidth = 4'd0;
    wdata  = 8'h96;
    wvalid = 1'b1;
    @(negedge clk);
    chk("alr_busy",   int'(busy),   1);
    chk("alr_level",  int'(level),  3);
    chk("alr_wready", int'(wready), 1);
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk("alr_busy2",  int'(busy),  0);
    chk("alr_level2", int'(level), 8);
    tick();
    rd(8, 'h96, 8, "alr1");

`ifdef IOB_BUNPACK_SIGN_EXT_EN
    wr(8'hA5);
    sign = 1'b1;
    rd(3, 'hFD, 8, "sgn0");
    sign = 1'b0;
    rd(5, 'h05, 5, "sgn1");
`endif

    // Width saturation
    wr(8'h3C);
    wr(8'hF0);
    rd(12, 'h3C, 16, "sat0");
    rd(15, 'hF0,  8, "sat1");

    // Clock enable low freezes everything
    cke    = 1'b0;
    wdata  = 8'h77;
    wvalid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("cke_level", int'(level), 0);
    cke = 1'b1;
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk("cke_level1", int'(level), 8);
    tick();
    rd(8, 'h77, 8, "cke1");

    // Synchronous clear in the middle of ALIGN
    wr(8'hA5);
    rwidth = 4'd3;
    rready = 1'b1;
    align  = 1'b1;
    tick();
    rready = 1'b0;
    align  = 1'b0;
    rwidth = 4'd0;
    rst    = 1'b1;
    @(negedge clk);
    chk("clr_busy0", int'(busy), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("clr_busy1",  int'(busy),  0);
    chk("clr_level1", int'(level), 0);
    tick();

    // Mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      wdata  = 8'(i * 37 + 11);
      wvalid = (i % 3) != 2;
      rwidth = 4'((i * 5) % 13);
      rready = (i % 4) != 1;
      align  = (i % 9) == 4;
      sign   = 1'(i % 2);
      tick();
    end
    wvalid = 1'b0;
    rready = 1'b0;
    align  = 1'b0;
    rwidth = 4'd0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
